// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard/forwarding controller:
// scoreboard entry layout, forwarding select encoding and the match helper.
package mips_pipe_pkg;

  // Register index width stored in a scoreboard entry; narrower core
  // register indices are zero-extended into it.
  localparam int SB_REG_W = 8;

  // Forwarding select encoding (k = result held in scoreboard slot k).
  localparam int FWD_RF     = 0;
  localparam int FWD_EX_MEM = 1;
  localparam int FWD_MEM_WB = 2;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
    logic                regwrite;
    logic                memread;
    logic [SB_REG_W-1:0] rs;
    logic [SB_REG_W-1:0] rt;
    logic                rs_used;
    logic                rt_used;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{
    valid:    1'b0,
    rd:       {SB_REG_W{1'b0}},
    regwrite: 1'b0,
    memread:  1'b0,
    rs:       {SB_REG_W{1'b0}},
    rt:       {SB_REG_W{1'b0}},
    rs_used:  1'b0,
    rt_used:  1'b0
  };

  // A slot produces register r when it is a real writer of r; $0 is never produced.
  function automatic logic slot_writes(input logic                valid,
                                       input logic                regwrite,
                                       input logic [SB_REG_W-1:0] rd,
                                       input logic [SB_REG_W-1:0] r);
    return valid && regwrite && (rd == r) && (r != {SB_REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/sb_match.sv
// Per-slot comparator: does this scoreboard slot produce either of two
// (used) source registers?
module sb_match
  import mips_pipe_pkg::*;
(
  input  logic                valid,
  input  logic                regwrite,
  input  logic [SB_REG_W-1:0] rd,
  input  logic [SB_REG_W-1:0] rs,
  input  logic [SB_REG_W-1:0] rt,
  input  logic                uses_rs,
  input  logic                uses_rt,
  output logic                hit_rs,
  output logic                hit_rt
);

  // Evaluate the match rule for both sources; unused sources never hit.
  always_comb begin
    hit_rs = uses_rs && slot_writes(valid, regwrite, rd, rs);
    hit_rt = uses_rt && slot_writes(valid, regwrite, rd, rt);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and flush controller. Keeps a scoreboard of in-flight
// writers (slot 0 = ID/EX .. slot DEPTH-1), derives EX forwarding selects,
// load-use stalls and branch/jump flushes, and counts stall/flush events.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter  int REG_W        = 5,
  parameter  int FWD_STAGES   = 2,
  parameter  int LOAD_LAT     = 1,
  parameter  int RESOLVE_SLOT = 1,
  parameter  int CNT_W        = 16,
  localparam int DEPTH        = FWD_STAGES + 1,
  localparam int FWD_W        = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sb_entry_t sb_r      [DEPTH];
  sb_entry_t sb_next_s [DEPTH];
  sb_entry_t id_entry_s;

  logic [DEPTH-1:1]    fwd_hit_rs_s;
  logic [DEPTH-1:1]    fwd_hit_rt_s;
  logic [LOAD_LAT-1:0] ld_hit_rs_s;
  logic [LOAD_LAT-1:0] ld_hit_rt_s;
  logic                stall_s;

  // Pack the instruction in ID into a scoreboard entry.
  always_comb begin
    id_entry_s          = SB_EMPTY;
    id_entry_s.valid    = 1'b1;
    id_entry_s.rd       = SB_REG_W'(id_rd);
    id_entry_s.regwrite = id_regwrite;
    id_entry_s.memread  = id_memread;
    id_entry_s.rs       = SB_REG_W'(id_rs);
    id_entry_s.rt       = SB_REG_W'(id_rt);
    id_entry_s.rs_used  = id_uses_rs;
    id_entry_s.rt_used  = id_uses_rt;
  end

  // Per-slot comparators: forwarding compares older slots against the
  // instruction in slot 0; load-use compares young slots against ID.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g >= 1) begin : g_fwd
      sb_match u_fwd_match (
        .valid    (sb_r[g].valid),
        .regwrite (sb_r[g].regwrite),
        .rd       (sb_r[g].rd),
        .rs       (sb_r[0].rs),
        .rt       (sb_r[0].rt),
        .uses_rs  (sb_r[0].rs_used),
        .uses_rt  (sb_r[0].rt_used),
        .hit_rs   (fwd_hit_rs_s[g]),
        .hit_rt   (fwd_hit_rt_s[g])
      );
    end
    if (g < LOAD_LAT) begin : g_ld
      sb_match u_ld_match (
        .valid    (sb_r[g].valid),
        .regwrite (sb_r[g].regwrite),
        .rd       (sb_r[g].rd),
        .rs       (id_entry_s.rs),
        .rt       (id_entry_s.rt),
        .uses_rs  (id_uses_rs),
        .uses_rt  (id_uses_rt),
        .hit_rs   (ld_hit_rs_s[g]),
        .hit_rt   (ld_hit_rt_s[g])
      );
    end
  end

  // Load-use stall: a load whose data is not yet forwardable feeds ID.
  always_comb begin
    stall_s = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (sb_r[j].memread && (ld_hit_rs_s[j] || ld_hit_rt_s[j])) begin
        stall_s = 1'b1;
      end else begin
        stall_s = stall_s;
      end
    end
    if (!id_valid) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // Forwarding priority encoder: the youngest matching producer wins.
  always_comb begin
    fwd_a = FWD_W'(FWD_RF);
    fwd_b = FWD_W'(FWD_RF);
    for (int j = FWD_STAGES; j >= FWD_EX_MEM; j--) begin
      if (fwd_hit_rs_s[j]) begin
        fwd_a = FWD_W'(j);
      end else begin
        fwd_a = fwd_a;
      end
      if (fwd_hit_rt_s[j]) begin
        fwd_b = FWD_W'(j);
      end else begin
        fwd_b = fwd_b;
      end
    end
    if (!sb_r[0].valid) begin
      fwd_a = FWD_W'(FWD_RF);
      fwd_b = FWD_W'(FWD_RF);
    end else begin
      fwd_a = fwd_a;
      fwd_b = fwd_b;
    end
  end

  // Pipeline handshake: redirect dominates a stall.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case ({redirect, stall_s})
      2'b10, 2'b11: begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      2'b01: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
      end
    endcase
  end

  // Next scoreboard contents: shift toward older slots, squash the
  // wrong-path slots younger than the resolving one on redirect.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      sb_next_s[j] = SB_EMPTY;
    end
    if (id_valid && !stall_s && !redirect) begin
      sb_next_s[0] = id_entry_s;
    end else begin
      sb_next_s[0] = SB_EMPTY;
    end
    for (int j = 1; j < DEPTH; j++) begin
      sb_next_s[j] = sb_r[j-1];
      if (redirect && ((j - 1) < RESOLVE_SLOT)) begin
        sb_next_s[j].valid = 1'b0;
      end else begin
        sb_next_s[j].valid = sb_r[j-1].valid;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        sb_r[j] <= SB_EMPTY;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        sb_r[j] <= sb_next_s[j];
      end
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && !redirect && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (redirect && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default instance and a deep instance
// (FWD_STAGES=3, LOAD_LAT=2, RESOLVE_SLOT=2, CNT_W=2) share one stimulus
// stream; a directed vector table, hand sequences and random cycles are
// checked against constants and an age-based pipeline model.
module tb_pipeline_hazard_ctrl;

  logic       clk, reset, id_valid, id_uses_rs, id_uses_rt;
  logic       id_regwrite, id_memread, redirect;
  logic [4:0] id_rs, id_rt, id_rd;

  logic        pc_write0, if_id_write0, if_id_flush0, id_ex_bubble0;
  logic [1:0]  fwd_a0, fwd_b0;
  logic [15:0] stall_cnt0, flush_cnt0;
  logic        pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [1:0]  stall_cnt1, flush_cnt1;

  pipeline_hazard_ctrl u_dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
    .pc_write(pc_write0), .if_id_write(if_id_write0), .if_id_flush(if_id_flush0),
    .id_ex_bubble(id_ex_bubble0), .fwd_a(fwd_a0), .fwd_b(fwd_b0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  pipeline_hazard_ctrl #(.FWD_STAGES(3), .LOAD_LAT(2), .RESOLVE_SLOT(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
    .id_ex_bubble(id_ex_bubble1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // in_flight[m][a] = instruction that has been in the pipe beyond ID for a cycles
  typedef struct {
    bit v; bit rw; bit mr; int rd; int rs; int rt; bit urs; bit urt;
  } ins_t;

  ins_t in_flight [0:1][0:7];
  int   m_sc [0:1];
  int   m_fc [0:1];
  int   p_fs  [0:1] = '{2, 3};
  int   p_ll  [0:1] = '{1, 2};
  int   p_rs  [0:1] = '{1, 2};
  int   p_max [0:1] = '{65535, 3};

  task automatic model_reset();
    ins_t nop_i;
    nop_i = '{default: 0};
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 8; a++) in_flight[m][a] = nop_i;
      m_sc[m] = 0;
      m_fc[m] = 0;
    end
  endtask

  function automatic bit produces(ins_t e, int r);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  function automatic bit m_stall(int m);
    if (!id_valid) return 1'b0;
    for (int a = 0; a < p_ll[m]; a++) begin
      if (in_flight[m][a].mr &&
          ((id_uses_rs && produces(in_flight[m][a], int'(id_rs))) ||
           (id_uses_rt && produces(in_flight[m][a], int'(id_rt)))))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(int m, bit use_rt);
    ins_t c;
    int   r;
    bit   u;
    c = in_flight[m][0];
    r = use_rt ? c.rt : c.rs;
    u = use_rt ? c.urt : c.urs;
    if (!c.v || !u) return 0;
    for (int a = 1; a <= p_fs[m]; a++) begin
      if (produces(in_flight[m][a], r)) return a;
    end
    return 0;
  endfunction

  task automatic m_step();
    ins_t nop_i, id_i;
    bit   st;
    nop_i = '{default: 0};
    id_i  = '{v: 1'b1, rw: id_regwrite, mr: id_memread, rd: int'(id_rd),
              rs: int'(id_rs), rt: int'(id_rt), urs: id_uses_rs, urt: id_uses_rt};
    for (int m = 0; m < 2; m++) begin
      st = m_stall(m);
      for (int a = p_fs[m]; a >= 1; a--) begin
        in_flight[m][a] = in_flight[m][a-1];
        if (redirect && (a - 1 < p_rs[m])) in_flight[m][a].v = 1'b0;
      end
      in_flight[m][0] = (id_valid && !st && !redirect) ? id_i : nop_i;
      if (st && !redirect && m_sc[m] < p_max[m]) m_sc[m]++;
      if (redirect && m_fc[m] < p_max[m]) m_fc[m]++;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(int m, bit pc, bit ifid, bit fl, bit bub, int fa, int fb, int sc, int fc);
    bit st;
    st = m_stall(m);
    check($sformatf("dut%0d_pc_write", m),     pc,   redirect ? 1 : (st ? 0 : 1));
    check($sformatf("dut%0d_if_id_write", m),  ifid, redirect ? 1 : (st ? 0 : 1));
    check($sformatf("dut%0d_if_id_flush", m),  fl,   redirect ? 1 : 0);
    check($sformatf("dut%0d_id_ex_bubble", m), bub,  (redirect || st) ? 1 : 0);
    check($sformatf("dut%0d_fwd_a", m), fa, m_fwd(m, 1'b0));
    check($sformatf("dut%0d_fwd_b", m), fb, m_fwd(m, 1'b1));
    check($sformatf("dut%0d_stall_cnt", m), sc, m_sc[m]);
    check($sformatf("dut%0d_flush_cnt", m), fc, m_fc[m]);
  endtask

  task automatic check_model();
    check_dut(0, pc_write0, if_id_write0, if_id_flush0, id_ex_bubble0, fwd_a0, fwd_b0, stall_cnt0, flush_cnt0);
    check_dut(1, pc_write1, if_id_write1, if_id_flush1, id_ex_bubble1, fwd_a1, fwd_b1, stall_cnt1, flush_cnt1);
  endtask

  task automatic drive(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit rdr);
    id_valid    = v;
    id_rs       = rs[4:0];
    id_rt       = rt[4:0];
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_rd       = rd[4:0];
    id_regwrite = rw;
    id_memread  = mr;
    redirect    = rdr;
  endtask

  // Drive one instruction and compare against the model at the falling edge.
  task automatic begin_cyc(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit rdr);
    drive(v, rs, rt, urs, urt, rd, rw, mr, rdr);
    @(negedge clk);
    check_model();
  endtask

  task automatic end_cyc();
    @(posedge clk);
    if (!reset) model_reset();
    else        m_step();
    #1;
  endtask

  // ---------------- directed vector table (default instance) ----------------
  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; int rd; bit rw; bit mr; bit rdr;
    bit e_pc; bit e_ifid; bit e_fl; bit e_bub; int e_fa; int e_fb; int e_sc; int e_fc;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit rdr,
                              bit pc, bit ifid, bit fl, bit bub, int fa, int fb, int sc, int fc);
    vec_t t;
    t = '{v, rs, rt, urs, urt, rd, rw, mr, rdr, pc, ifid, fl, bub, fa, fb, sc, fc};
    return t;
  endfunction

  // one lw/dependent-add pair seen by both instances; k = pair number
  task automatic lw_use_pair(int k);
    begin_cyc(1, 29, 0, 1, 0, 2, 1, 1, 0); end_cyc();
    begin_cyc(1, 2, 2, 1, 1, 6, 1, 0, 0);
    check("ll2_stall1_pc", pc_write1, 0);
    end_cyc();
    begin_cyc(1, 2, 2, 1, 1, 6, 1, 0, 0);
    check("ll2_stall2_pc", pc_write1, 0);
    check("ll2_stall2_bubble", id_ex_bubble1, 1);
    end_cyc();
    begin_cyc(1, 2, 2, 1, 1, 6, 1, 0, 0);
    check("ll2_release_pc", pc_write1, 1);
    check("ll2_release_bubble", id_ex_bubble1, 0);
    end_cyc();
    begin_cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ll2_fwd_a", fwd_a1, 3);
    check("ll2_fwd_b", fwd_b1, 3);
    check("ll2_stall_cnt_sat", stall_cnt1, (2 * k > 3) ? 3 : 2 * k);
    check("ll1_stall_cnt", stall_cnt0, k);
    end_cyc();
  endtask

  initial begin
    //            v  rs  rt urs urt rd rw mr rdr | pc ifid fl bub fa fb sc fc
    tbl[0]  = mk(1, 1,  2,  1, 1,  3, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3,  5,  1, 1,  4, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0,  0,  0, 0,  0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1,  2,  1, 1,  3, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 9,  10, 1, 1,  8, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 3,  8,  1, 1, 12, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0,  0,  0, 0,  0, 0, 0, 0,   1, 1, 0, 0, 2, 1, 0, 0);
    tbl[7]  = mk(1, 29, 0,  1, 0,  2, 1, 1, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 2,  2,  1, 1,  6, 1, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);
    tbl[9]  = mk(1, 2,  2,  1, 1,  6, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0,  0,  0, 0,  0, 0, 0, 0,   1, 1, 0, 0, 2, 2, 1, 0);
    tbl[11] = mk(1, 1,  0,  1, 0,  0, 1, 1, 0,   1, 1, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 0,  0,  1, 1,  5, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 0,  0,  0, 0, 31, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(1, 31, 0,  1, 0,  9, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0,  0,  0, 0,  0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1, 0);
    tbl[16] = mk(1, 29, 0,  1, 0,  2, 1, 1, 0,   1, 1, 0, 0, 0, 0, 1, 0);
    tbl[17] = mk(1, 2,  2,  1, 1,  6, 1, 0, 1,   1, 1, 1, 1, 0, 0, 1, 0);
    tbl[18] = mk(1, 2,  2,  1, 1,  6, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 1);
    tbl[19] = mk(0, 0,  0,  0, 0,  0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 1);
    tbl[20] = mk(0, 0,  0,  0, 0,  0, 0, 0, 1,   1, 1, 1, 1, 0, 0, 1, 1);
    tbl[21] = mk(0, 0,  0,  0, 0,  0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 2);

    // reset state
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check("reset_pc_write", pc_write0, 1);
    check("reset_if_id_write", if_id_write0, 1);
    check("reset_if_id_flush", if_id_flush0, 0);
    check("reset_id_ex_bubble", id_ex_bubble0, 0);
    check("reset_fwd_a", fwd_a0, 0);
    check("reset_stall_cnt1", stall_cnt1, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // directed table
    for (int i = 0; i < 22; i++) begin
      begin_cyc(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].rdr);
      check($sformatf("tbl%0d_pc_write", i), pc_write0, tbl[i].e_pc);
      check($sformatf("tbl%0d_if_id_write", i), if_id_write0, tbl[i].e_ifid);
      check($sformatf("tbl%0d_if_id_flush", i), if_id_flush0, tbl[i].e_fl);
      check($sformatf("tbl%0d_id_ex_bubble", i), id_ex_bubble0, tbl[i].e_bub);
      check($sformatf("tbl%0d_fwd_a", i), fwd_a0, tbl[i].e_fa);
      check($sformatf("tbl%0d_fwd_b", i), fwd_b0, tbl[i].e_fb);
      check($sformatf("tbl%0d_stall_cnt", i), stall_cnt0, tbl[i].e_sc);
      check($sformatf("tbl%0d_flush_cnt", i), flush_cnt0, tbl[i].e_fc);
      end_cyc();
    end

    // reset asserted in the middle of a load-use stall
    begin_cyc(1, 29, 0, 1, 0, 2, 1, 1, 0); end_cyc();
    begin_cyc(1, 2, 2, 1, 1, 6, 1, 0, 0);
    check("pre_reset_stall", pc_write0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("midrst_pc_write", pc_write0, 1);
    check("midrst_if_id_write", if_id_write0, 1);
    check("midrst_if_id_flush", if_id_flush0, 0);
    check("midrst_id_ex_bubble", id_ex_bubble0, 0);
    check("midrst_fwd_a", fwd_a0, 0);
    check("midrst_fwd_b", fwd_b0, 0);
    check("midrst_stall_cnt", stall_cnt0, 0);
    check("midrst_flush_cnt", flush_cnt0, 0);
    check("midrst_dut1_pc_write", pc_write1, 1);
    check_model();
    end_cyc();
    reset = 1'b1;
    begin_cyc(1, 2, 2, 1, 1, 6, 1, 0, 0);
    check("resume_no_bubble", id_ex_bubble0, 0);
    end_cyc();

    // deep instance: 2-cycle load-use, fwd from slot 3, counter saturation
    for (int k = 1; k <= 3; k++) lw_use_pair(k);

    // randomized stream against the model
    for (int n = 0; n < 400; n++) begin
      begin_cyc(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0));
      end_cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
